// File: rtl/nonce_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nonce_ctrl_pkg
// Brief    : Shared state encoding and default watchdog depth for the search.
// Revision : 1.0
// ============================================================================
package nonce_ctrl_pkg;

    localparam int unsigned c_timeout_default = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        FOUND   = 3'd3,
        EXHAUST = 3'd4,
        ERROR   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nonce_search_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nonce_search_ctrl_if
// Brief    : Host and hash-core signal bundle of the nonce search controller.
// Revision : 1.0
// ============================================================================
interface nonce_search_ctrl_if;

    logic        start;
    logic        abort;
    logic [31:0] nonce_start;
    logic [31:0] nonce_limit;
    logic        hash_done;
    logic        hash_hit;
    logic        core_start;
    logic [31:0] core_nonce;
    logic        busy;
    logic        finished;
    logic        valid_sal;
    logic [31:0] nonce_out;
    logic        timeout_err;
    logic [31:0] attempts;

    modport slave (
        input  start, abort, nonce_start, nonce_limit, hash_done, hash_hit,
        output core_start, core_nonce, busy, finished, valid_sal, nonce_out,
               timeout_err, attempts
    );

    modport master (
        output start, abort, nonce_start, nonce_limit, hash_done, hash_hit,
        input  core_start, core_nonce, busy, finished, valid_sal, nonce_out,
               timeout_err, attempts
    );

endinterface
`default_nettype wire

// File: rtl/hash_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : hash_watchdog
// Brief    : Per-nonce response timer; expired flags the last allowed cycle.
// Revision : 1.0
// ============================================================================
module hash_watchdog
    import nonce_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_timeout_default
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int unsigned       c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Counter saturates at the last cycle; the controller leaves WAIT there.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/nonce_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nonce_search_ctrl
// Brief    : Walks a nonce range through a hash core until hit, end or timeout.
// Revision : 1.0
// ============================================================================
module nonce_search_ctrl
    import nonce_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_timeout_default
) (
    input  wire logic          clk,
    input  wire logic          reset,
    nonce_search_ctrl_if.slave bus
);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_nonce, w_nonce_nxt;
    logic [31:0] r_limit, w_limit_nxt;
    logic [31:0] r_nonce_out, w_nonce_out_nxt;
    logic [31:0] r_attempts, w_attempts_nxt;
    logic        r_finished, w_finished_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        r_core_start;
    logic        r_busy;
    logic        w_start_ok;
    logic        w_expired;

    hash_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state == ISSUE),
        .enable  (r_state == WAIT),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_nonce_nxt     = r_nonce;
        w_limit_nxt     = r_limit;
        w_nonce_out_nxt = r_nonce_out;
        w_attempts_nxt  = r_attempts;
        w_finished_nxt  = r_finished;
        w_valid_nxt     = r_valid;
        w_timeout_nxt   = r_timeout;
        w_start_ok      = bus.start && (r_state inside {IDLE, FOUND, EXHAUST, ERROR});

        if (bus.abort) begin
            if (r_state != IDLE) begin
                w_state_nxt     = IDLE;
                w_finished_nxt  = 1'b0;
                w_valid_nxt     = 1'b0;
                w_timeout_nxt   = 1'b0;
                w_nonce_out_nxt = '0;
            end
        end else if (w_start_ok) begin
            w_nonce_nxt     = bus.nonce_start;
            w_limit_nxt     = bus.nonce_limit;
            w_attempts_nxt  = '0;
            w_nonce_out_nxt = '0;
            w_valid_nxt     = 1'b0;
            w_timeout_nxt   = 1'b0;
            if (bus.nonce_start > bus.nonce_limit) begin
                w_state_nxt    = EXHAUST;
                w_finished_nxt = 1'b1;
            end else begin
                w_state_nxt    = ISSUE;
                w_finished_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                ISSUE: w_state_nxt = WAIT;
                WAIT: begin
                    // A result on the expiry cycle wins over the timeout.
                    if (bus.hash_done) begin
                        w_attempts_nxt = r_attempts + 32'd1;
                        if (bus.hash_hit) begin
                            w_state_nxt     = FOUND;
                            w_nonce_out_nxt = r_nonce;
                            w_valid_nxt     = 1'b1;
                            w_finished_nxt  = 1'b1;
                        end else if (r_nonce == r_limit) begin
                            w_state_nxt    = EXHAUST;
                            w_finished_nxt = 1'b1;
                        end else begin
                            w_nonce_nxt = r_nonce + 32'd1;
                            w_state_nxt = ISSUE;
                        end
                    end else if (w_expired) begin
                        w_state_nxt    = ERROR;
                        w_timeout_nxt  = 1'b1;
                        w_finished_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_nonce      <= '0;
            r_limit      <= '0;
            r_nonce_out  <= '0;
            r_attempts   <= '0;
            r_finished   <= 1'b0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_nonce      <= w_nonce_nxt;
            r_limit      <= w_limit_nxt;
            r_nonce_out  <= w_nonce_out_nxt;
            r_attempts   <= w_attempts_nxt;
            r_finished   <= w_finished_nxt;
            r_valid      <= w_valid_nxt;
            r_timeout    <= w_timeout_nxt;
            r_core_start <= (w_state_nxt == ISSUE);
            r_busy       <= (w_state_nxt == ISSUE) || (w_state_nxt == WAIT);
        end
    end

    assign bus.core_start  = r_core_start;
    assign bus.core_nonce  = r_nonce;
    assign bus.busy        = r_busy;
    assign bus.finished    = r_finished;
    assign bus.valid_sal   = r_valid;
    assign bus.nonce_out   = r_nonce_out;
    assign bus.timeout_err = r_timeout;
    assign bus.attempts    = r_attempts;

endmodule
`default_nettype wire

// File: doc/nonce_search_ctrl.md
NONCE_SEARCH_CTRL -- requirements
Module: nonce_search_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum number of cycles to wait for hash_done per nonce.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a search; sampled in IDLE, FOUND, EXHAUST and ERROR.
REQ-005 abort  input  1  cancel any search in progress.
REQ-006 nonce_start  input  32  first nonce of the range, captured on an accepted start.
REQ-007 nonce_limit  input  32  last nonce of the range (inclusive), captured on an accepted start.
REQ-008 hash_done  input  1  hash core result strobe.
REQ-009 hash_hit  input  1  hash meets target; qualified by hash_done.
REQ-010 core_start  output  1  one-cycle launch pulse to the hash core.
REQ-011 core_nonce  output  32  nonce currently presented to the hash core.
REQ-012 busy  output  1  high in ISSUE and WAIT.
REQ-013 finished  output  1  search ended: found, exhausted or error.
REQ-014 valid_sal  output  1  a hit was found; nonce_out is valid.
REQ-015 nonce_out  output  32  winning nonce; 0 unless valid_sal=1.
REQ-016 timeout_err  output  1  the hash core failed to respond within TIMEOUT cycles.
REQ-017 attempts  output  32  count of hash_done events accepted in the current search.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT, FOUND, EXHAUST and ERROR; all outputs are registered.
REQ-019 In IDLE, start=1 SHALL capture nonce_start/nonce_limit, clear attempts and go to ISSUE next cycle; if nonce_start>nonce_limit it SHALL go to EXHAUST instead.
REQ-020 ISSUE SHALL last exactly one cycle with core_start=1 and core_nonce=current nonce, then go to WAIT with the watchdog cleared.
REQ-021 In WAIT, hash_done=1 SHALL increment attempts (wrapping at 2^32).
REQ-022 In WAIT, hash_done=1 with hash_hit=1 SHALL go to FOUND with nonce_out=core_nonce, valid_sal=1 and finished=1.
REQ-023 In WAIT, hash_done=1 with hash_hit=0 SHALL go to EXHAUST if core_nonce==nonce_limit, otherwise core_nonce SHALL increment by 1 and the block SHALL go to ISSUE.
REQ-024 The nonce SHALL never wrap: with limit 0xFFFFFFFF, the nonce 0xFFFFFFFF ends the search without incrementing.
REQ-025 In WAIT, if TIMEOUT cycles elapse without hash_done, the block SHALL go to ERROR with timeout_err=1 and finished=1; a hash_done on the expiry cycle takes priority over the timeout.
REQ-026 EXHAUST SHALL hold finished=1, valid_sal=0 and nonce_out=0.
REQ-027 FOUND, EXHAUST and ERROR SHALL be held until start or abort; start in these states SHALL clear the result outputs and behave as start from IDLE.
REQ-028 abort=1 in any state other than IDLE SHALL go to IDLE next cycle with core_start=0 and finished/valid_sal/timeout_err cleared; abort SHALL take priority over start, hash_done and timeout.
REQ-029 hash_done outside WAIT SHALL be ignored.
REQ-030 start while busy SHALL be ignored.

Reset
REQ-031 reset=1 SHALL force IDLE and set core_start=0, core_nonce=0, busy=0, finished=0, valid_sal=0, nonce_out=0, timeout_err=0, attempts=0 and the watchdog to 0.
REQ-032 Reset SHALL take priority over abort and all other inputs, including mid-search, and the hash_done that follows SHALL be ignored.

Structure
REQ-033 The state enum and the TIMEOUT default SHALL live in the shared package nonce_ctrl_pkg.
REQ-034 The per-nonce timeout counter SHALL be a sub-module, hash_watchdog, with inputs clear, enable and TIMEOUT, and output expired.

Verification
REQ-035 Scenario: range 0x10..0x13, hit at 0x12 after a 3-cycle latency -> valid_sal=1, nonce_out=0x12, attempts=3, core_start pulsed 3 times.
REQ-036 Scenario: range 0x0..0x2, never hit -> EXHAUST, finished=1, valid_sal=0, nonce_out=0, attempts=3.
REQ-037 Scenario: range 0xFFFFFFFE..0xFFFFFFFF, no hit -> exactly 2 launches, EXHAUST, no wrap to 0.
REQ-038 Scenario: TIMEOUT=8, hash core silent -> timeout_err=1 and finished=1 eight cycles after core_start; hash_done on cycle 8 -> normal handling instead.
REQ-039 Scenario: abort in WAIT, then a late hash_done -> IDLE, all flags 0, attempts unchanged.
REQ-040 Scenario: reset during WAIT, then start with nonce_start=5 and nonce_limit=4 -> EXHAUST next cycle with zero launches.
